// File: rtl/alu_share_ctrl.sv
// Round-robin sharer of one alu_8bit between two valid/ready requesters; result returned on a tagged response channel.
// Accept-to-rsp_valid is ALU_LAT+1 cycles; a stalled response (rsp_ready low) holds the block and blocks new grants.
module alu_share_ctrl #(
    parameter int W       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_sel,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_result,
    input  logic         alu_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_cout,
    output logic         rsp_id,
    output logic         busy,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
    } op_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    state_t     state;
    state_t     next_state;
    logic       last_grant;
    logic [3:0] lat_cnt;
    op_t        op_q;
    op_t        op_in;
    logic       id_q;
    logic       grant0;
    logic       grant1;
    logic       take;
    logic       take_id;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign take       = req0_ready | req1_ready;
    assign take_id    = req1_ready;

    always_comb begin
        op_in = '{a: req0_a, b: req0_b, sel: req0_sel};
        if (take_id) begin
            op_in = '{a: req1_a, b: req1_b, sel: req1_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (take) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operands stay registered after the response so the ALU inputs only move on a new accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            lat_cnt    <= 4'd0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
            op_count   <= 16'd0;
        end else begin
            if (take) begin
                op_q       <= op_in;
                id_q       <= take_id;
                last_grant <= take_id;
                lat_cnt    <= LAT_INIT;
            end
            if (state == EXEC) begin
                if (lat_cnt != 4'd0) begin
                    lat_cnt <= lat_cnt - 4'd1;
                end else begin
                    rsp_result <= alu_result;
                    rsp_cout   <= alu_cout;
                    rsp_id     <= id_q;
                end
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

    assign alu_a   = op_q.a;
    assign alu_b   = op_q.b;
    assign alu_sel = op_q.sel;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (ALU_LAT 1 and 3) against a transaction-level model plus directed cases.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       vld   [2][2];
    logic       rdy   [2][2];
    logic [7:0] opa   [2][2];
    logic [7:0] opb   [2][2];
    logic [2:0] ops   [2][2];
    logic [7:0] alu_a [2];
    logic [7:0] alu_b [2];
    logic [2:0] alu_sel [2];
    logic [7:0] alu_res [2];
    logic       alu_co [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_result [2];
    logic       rsp_cout [2];
    logic       rsp_id [2];
    logic       busy [2];
    logic [15:0] op_count [2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    alu_share_ctrl #(.W(8), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0][0]), .req0_ready(rdy[0][0]), .req0_a(opa[0][0]), .req0_b(opb[0][0]), .req0_sel(ops[0][0]),
        .req1_valid(vld[0][1]), .req1_ready(rdy[0][1]), .req1_a(opa[0][1]), .req1_b(opb[0][1]), .req1_sel(ops[0][1]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_result(alu_res[0]), .alu_cout(alu_co[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]), .rsp_cout(rsp_cout[0]),
        .rsp_id(rsp_id[0]), .busy(busy[0]), .op_count(op_count[0])
    );

    alu_share_ctrl #(.W(8), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0_valid(vld[1][0]), .req0_ready(rdy[1][0]), .req0_a(opa[1][0]), .req0_b(opb[1][0]), .req0_sel(ops[1][0]),
        .req1_valid(vld[1][1]), .req1_ready(rdy[1][1]), .req1_a(opa[1][1]), .req1_b(opb[1][1]), .req1_sel(ops[1][1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_result(alu_res[1]), .alu_cout(alu_co[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]), .rsp_cout(rsp_cout[1]),
        .rsp_id(rsp_id[1]), .busy(busy[1]), .op_count(op_count[1])
    );

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b};
            3'd1:    alu_f = {1'b0, a} - {1'b0, b};
            3'd2:    alu_f = {1'b0, a & b};
            3'd3:    alu_f = {1'b0, a | b};
            3'd4:    alu_f = {1'b0, a ^ b};
            default: alu_f = {1'b0, a};
        endcase
    endfunction

    always_comb begin
        {alu_co[0], alu_res[0]} = alu_f(alu_a[0], alu_b[0], alu_sel[0]);
        {alu_co[1], alu_res[1]} = alu_f(alu_a[1], alu_b[1], alu_sel[1]);
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Transaction-level model: remaining exec cycles, pending response, completed count.
    int          m_left [2];
    bit          m_rsp  [2];
    logic [7:0]  m_res  [2];
    logic        m_cout [2];
    logic        m_id   [2];
    logic        m_last [2];
    logic [15:0] m_cnt  [2];
    logic [7:0]  m_a    [2];
    logic [7:0]  m_b    [2];
    logic [2:0]  m_sel  [2];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit idle, g0, g1;
                int lat, r;
                lat  = (k == 0) ? 1 : 3;
                idle = (m_left[k] == 0) && !m_rsp[k];
                g0   = idle && vld[k][0] && (!vld[k][1] || m_last[k]);
                g1   = idle && vld[k][1] && (!vld[k][0] || !m_last[k]);
                check("req0_ready", k, rdy[k][0], g0);
                check("req1_ready", k, rdy[k][1], g1);
                check("busy", k, busy[k], !idle);
                check("rsp_valid", k, rsp_valid[k], m_rsp[k]);
                check("alu_a", k, alu_a[k], m_a[k]);
                check("alu_b", k, alu_b[k], m_b[k]);
                check("alu_sel", k, alu_sel[k], m_sel[k]);
                check("op_count", k, op_count[k], m_cnt[k]);
                if (m_rsp[k]) begin
                    check("rsp_result", k, rsp_result[k], m_res[k]);
                    check("rsp_cout", k, rsp_cout[k], m_cout[k]);
                    check("rsp_id", k, rsp_id[k], m_id[k]);
                end
                if (rst) begin
                    m_left[k] = 0; m_rsp[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
                    m_a[k] = 0; m_b[k] = 0; m_sel[k] = 0;
                end else if (m_rsp[k]) begin
                    if (rsp_ready[k]) begin
                        m_rsp[k] = 0;
                        m_cnt[k] = m_cnt[k] + 16'd1;
                    end
                end else if (m_left[k] > 0) begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_rsp[k] = 1;
                end else if (g0 || g1) begin
                    r = g1 ? 1 : 0;
                    m_a[k] = opa[k][r]; m_b[k] = opb[k][r]; m_sel[k] = ops[k][r];
                    {m_cout[k], m_res[k]} = alu_f(opa[k][r], opb[k][r], ops[k][r]);
                    m_id[k] = r[0]; m_last[k] = r[0];
                    m_left[k] = lat;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        bit ok;
        ok = 0;
        vld[k][r] = 1; opa[k][r] = a; opb[k][r] = b; ops[k][r] = s;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (rdy[k][r]) ok = 1;
            tick();
        end
        vld[k][r] = 0;
        if (!ok) fail("send_accept");
    endtask

    task automatic wait_rsp(input int k);
        bit ok;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid[k]) ok = 1;
            else tick();
        end
        if (!ok) fail("wait_rsp");
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (!busy[k]) ok = 1;
            tick();
        end
        if (!ok) fail("wait_idle");
    endtask

    initial begin
        bit acc [2][2];
        int seq [$];
        int got;
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            rsp_ready[k] = 1;
            m_left[k] = 0; m_rsp[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
            m_a[k] = 0; m_b[k] = 0; m_sel[k] = 0; m_res[k] = 0; m_cout[k] = 0; m_id[k] = 0;
            for (int r = 0; r < 2; r++) begin
                vld[k][r] = 0; opa[k][r] = 0; opb[k][r] = 0; ops[k][r] = 0; acc[k][r] = 0;
            end
        end
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("rst_busy", 0, busy[0], 0);
        check("rst_rsp_valid", 0, rsp_valid[0], 0);
        check("rst_op_count", 0, op_count[0], 0);
        check("rst_alu_a", 0, alu_a[0], 0);
        tick();

        // First operation: 3+2 from requester 0.
        vld[0][0] = 1; opa[0][0] = 8'd3; opb[0][0] = 8'd2; ops[0][0] = 3'd0;
        @(negedge clk);
        check("t1_ready_c0", 0, rdy[0][0], 1);
        tick();
        vld[0][0] = 0;
        @(negedge clk);
        check("t1_valid_c1", 0, rsp_valid[0], 0);
        tick();
        @(negedge clk);
        check("t1_valid_c2", 0, rsp_valid[0], 1);
        check("t1_result", 0, rsp_result[0], 8'd5);
        check("t1_cout", 0, rsp_cout[0], 0);
        check("t1_id", 0, rsp_id[0], 0);
        tick();
        @(negedge clk);
        check("t1_op_count", 0, op_count[0], 1);
        tick();

        // Both requesters held high: grants must alternate starting with 0 after reset.
        rst = 1;
        tick();
        rst = 0;
        for (int r = 0; r < 2; r++) begin
            vld[0][r] = 1; opa[0][r] = 8'($urandom); opb[0][r] = 8'($urandom); ops[0][r] = 3'($urandom);
        end
        for (int c = 0; c < 60 && seq.size() < 3; c++) begin
            @(negedge clk);
            check("both_ready", 0, rdy[0][0] & rdy[0][1], 0);
            got = rdy[0][0] ? 0 : (rdy[0][1] ? 1 : -1);
            tick();
            if (got >= 0) begin
                seq.push_back(got);
                opa[0][got] = 8'($urandom); opb[0][got] = 8'($urandom);
                if (seq.size() == 3) begin
                    vld[0][0] = 0; vld[0][1] = 0;
                end
            end
        end
        vld[0][0] = 0; vld[0][1] = 0;
        if (seq.size() == 3) begin
            check("grant_seq0", 0, seq[0], 0);
            check("grant_seq1", 0, seq[1], 1);
            check("grant_seq2", 0, seq[2], 0);
        end else begin
            fail("grant_seq");
        end
        wait_idle(0);

        // Overflow from requester 1.
        send(0, 1, 8'hFF, 8'h01, 3'd0);
        wait_rsp(0);
        check("ovf_result", 0, rsp_result[0], 8'h00);
        check("ovf_cout", 0, rsp_cout[0], 1);
        check("ovf_id", 0, rsp_id[0], 1);
        tick();
        wait_idle(0);

        // Backpressure: response held while a competing request waits.
        rsp_ready[0] = 0;
        send(0, 0, 8'h10, 8'h07, 3'd1);
        wait_rsp(0);
        tick();
        vld[0][1] = 1; opa[0][1] = 8'd1; opb[0][1] = 8'd1; ops[0][1] = 3'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 0, rsp_valid[0], 1);
            check("bp_result", 0, rsp_result[0], 8'h09);
            check("bp_rdy0", 0, rdy[0][0], 0);
            check("bp_rdy1", 0, rdy[0][1], 0);
            check("bp_busy", 0, busy[0], 1);
            tick();
        end
        rsp_ready[0] = 1;
        @(negedge clk);
        check("bp_release_valid", 0, rsp_valid[0], 1);
        tick();
        @(negedge clk);
        check("bp_next_accept", 0, rdy[0][1], 1);
        tick();
        vld[0][1] = 0;
        wait_idle(0);

        // ALU_LAT=3: operands held for three EXEC cycles.
        vld[1][0] = 1; opa[1][0] = 8'h5A; opb[1][0] = 8'h33; ops[1][0] = 3'd1;
        @(negedge clk);
        check("lat3_ready", 1, rdy[1][0], 1);
        tick();
        vld[1][0] = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lat3_alu_a", 1, alu_a[1], 8'h5A);
            check("lat3_alu_b", 1, alu_b[1], 8'h33);
            check("lat3_no_rsp", 1, rsp_valid[1], 0);
            tick();
        end
        @(negedge clk);
        check("lat3_rsp_valid", 1, rsp_valid[1], 1);
        check("lat3_result", 1, rsp_result[1], 8'h27);
        tick();
        wait_idle(1);

        // Reset while inst0 is in RESP and inst1 is in EXEC.
        rsp_ready[0] = 0;
        vld[0][0] = 1; opa[0][0] = 8'h11; opb[0][0] = 8'h22; ops[0][0] = 3'd0;
        vld[1][1] = 1; opa[1][1] = 8'h44; opb[1][1] = 8'h05; ops[1][1] = 3'd0;
        @(negedge clk);
        check("rr_ready0", 0, rdy[0][0], 1);
        check("rr_ready1", 1, rdy[1][1], 1);
        tick();
        vld[0][0] = 0; vld[1][1] = 0;
        tick();
        @(negedge clk);
        check("rr_in_resp", 0, rsp_valid[0], 1);
        check("rr_in_exec", 1, busy[1], 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        rsp_ready[0] = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("rr_rsp_valid", k, rsp_valid[k], 0);
                check("rr_busy", k, busy[k], 0);
                check("rr_op_count", k, op_count[k], 0);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            vld[k][0] = 1; vld[k][1] = 1;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rr_first_grant0", k, rdy[k][0], 1);
            check("rr_first_grant1", k, rdy[k][1], 0);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            vld[k][0] = 0; vld[k][1] = 0;
        end
        wait_idle(0);
        wait_idle(1);

        // Random traffic with random backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 2; r++)
                    acc[k][r] = vld[k][r] && rdy[k][r];
            tick();
            rst = (c % 1000 == 500);
            for (int k = 0; k < 2; k++) begin
                rsp_ready[k] = ($urandom_range(3) != 0);
                for (int r = 0; r < 2; r++) begin
                    if (!vld[k][r] || acc[k][r]) begin
                        vld[k][r] = ($urandom_range(2) == 0);
                        opa[k][r] = 8'($urandom);
                        opb[k][r] = 8'($urandom);
                        ops[k][r] = 3'($urandom);
                    end else if ($urandom_range(15) == 0) begin
                        vld[k][r] = 0;
                    end
                end
            end
        end
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            rsp_ready[k] = 1;
            vld[k][0] = 0; vld[k][1] = 0;
        end
        wait_idle(0);
        wait_idle(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
